// File: rtl/paddle_ctrl.sv
// Paddle motion and size controller: once per frame (rising vsync) moves the paddle with
// acceleration, runs the widen power-up FSM and clamps the paddle inside the playfield.
module paddle_ctrl #(
    parameter int unsigned LEFT        = 160,
    parameter int unsigned MAXX        = 320,
    parameter int unsigned PD_Y        = 464,
    parameter int unsigned R_NORM      = 24,
    parameter int unsigned R_WIDE      = 40,
    parameter int unsigned VMAX        = 4,
    parameter int unsigned WIDE_FRAMES = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       widen_req,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [5:0] radius,
    output logic       wide
);

    localparam int unsigned TW = $clog2(WIDE_FRAMES + 1);

    typedef enum logic [1:0] {StNormal, StGrow, StHold, StShrink} state_e;
    typedef enum logic [1:0] {DirNone, DirLeft, DirRight} dir_e;

    state_e          state_q, state_d;
    dir_e            dir_q, dir_d, cur_dir;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      speed_q, speed_d;
    logic [9:0]      x_q, x_d;
    logic [5:0]      radius_q, radius_d;
    logic            pending_q, pending_d;
    logic            vsync_d;
    logic            tick, pend;
    logic [10:0]     xp, lo, hi;

    assign tick   = vsync & ~vsync_d;
    assign pend   = pending_q | widen_req;
    assign x      = x_q;
    assign y      = 10'(PD_Y);
    assign radius = radius_q;
    assign wide   = (state_q != StNormal);

    always_comb begin
        cur_dir = DirNone;
        if (btn_left && !btn_right) begin
            cur_dir = DirLeft;
        end else if (btn_right && !btn_left) begin
            cur_dir = DirRight;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        timer_d   = timer_q;
        speed_d   = speed_q;
        x_d       = x_q;
        radius_d  = radius_q;
        pending_d = pend;
        xp        = {1'b0, x_q};
        lo        = '0;
        hi        = '0;

        if (tick) begin
            pending_d = 1'b0;
            dir_d     = cur_dir;

            if (cur_dir == DirNone || cur_dir != dir_q) begin
                speed_d = (cur_dir == DirNone) ? 3'd0 : 3'd1;
            end else if (speed_q < 3'(VMAX)) begin
                speed_d = speed_q + 3'd1;
            end

            // x never sits closer than LEFT+R_NORM to zero, so the subtraction cannot wrap
            case (cur_dir)
                DirLeft:  xp = {1'b0, x_q} - {8'd0, speed_d};
                DirRight: xp = {1'b0, x_q} + {8'd0, speed_d};
                default:  xp = {1'b0, x_q};
            endcase

            unique case (state_q)
                StNormal: begin
                    if (pend) state_d = StGrow;
                end
                StGrow: begin
                    radius_d = radius_q + 6'd1;
                    if (radius_d == 6'(R_WIDE)) begin
                        state_d = StHold;
                        timer_d = TW'(WIDE_FRAMES);
                    end
                end
                StHold: begin
                    if (pend) begin
                        timer_d = TW'(WIDE_FRAMES);
                    end else begin
                        timer_d = timer_q - TW'(1);
                        if (timer_d == '0) state_d = StShrink;
                    end
                end
                StShrink: begin
                    // A new power-up resumes growth from wherever the shrink had got to
                    if (pend) begin
                        state_d = StGrow;
                    end else begin
                        radius_d = radius_q - 6'd1;
                        if (radius_d == 6'(R_NORM)) state_d = StNormal;
                    end
                end
                default: state_d = StNormal;
            endcase

            lo = 11'(LEFT) + {5'd0, radius_d};
            hi = 11'(LEFT + MAXX) - {5'd0, radius_d};
            if (xp < lo) begin
                x_d = lo[9:0];
            end else if (xp > hi) begin
                x_d = hi[9:0];
            end else begin
                x_d = xp[9:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StNormal;
            dir_q     <= DirNone;
            timer_q   <= '0;
            speed_q   <= '0;
            x_q       <= 10'(LEFT + MAXX / 2);
            radius_q  <= 6'(R_NORM);
            pending_q <= 1'b0;
            vsync_d   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            speed_q   <= speed_d;
            x_q       <= x_d;
            radius_q  <= radius_d;
            pending_q <= pending_d;
            vsync_d   <= vsync;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus randomized frames, all
// compared against a frame-level behavioural model.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst, vsync, btn_left, btn_right, widen_req;
    logic [9:0] x, y;
    logic [5:0] radius;
    logic       wide;

    int errors = 0;
    int checks = 0;

    // Model: phase 0=normal 1=grow 2=hold 3=shrink
    int m_x, m_r, m_ph, m_tmr, m_spd, m_dir;
    bit m_pend;

    paddle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .widen_req (widen_req),
        .x         (x),
        .y         (y),
        .radius    (radius),
        .wide      (wide)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_r = 24; m_ph = 0; m_tmr = 0; m_spd = 0; m_dir = 0; m_pend = 0;
    endtask

    task automatic model_tick(input bit bl, input bit br);
        int d;
        int xp;
        d = (bl && !br) ? -1 : (br && !bl) ? 1 : 0;
        if (d == 0 || d != m_dir) m_spd = (d == 0) ? 0 : 1;
        else m_spd = (m_spd + 1 > 4) ? 4 : m_spd + 1;
        m_dir = d;
        xp = m_x + d * m_spd;
        case (m_ph)
            0: if (m_pend) m_ph = 1;
            1: begin
                m_r++;
                if (m_r == 40) begin m_ph = 2; m_tmr = 600; end
            end
            2: begin
                if (m_pend) m_tmr = 600;
                else begin
                    m_tmr--;
                    if (m_tmr == 0) m_ph = 3;
                end
            end
            default: begin
                if (m_pend) m_ph = 1;
                else begin
                    m_r--;
                    if (m_r == 24) m_ph = 0;
                end
            end
        endcase
        m_pend = 0;
        if (xp - m_r < 160) m_x = 160 + m_r;
        else if (xp + m_r > 480) m_x = 480 - m_r;
        else m_x = xp;
    endtask

    task automatic check_outputs();
        chk("x", int'(x), m_x);
        chk("radius", int'(radius), m_r);
        chk("wide", int'(wide), (m_ph != 0) ? 1 : 0);
        chk("y", int'(y), 464);
        chk("bounds", (int'(x) - int'(radius) >= 160 && int'(x) + int'(radius) <= 480) ? 1 : 0, 1);
    endtask

    // wmode: 0 none, 1 widen pulse mid-frame, 2 widen pulse coincident with the tick
    task automatic frame(input bit bl, input bit br, input int wmode);
        @(negedge clk);
        vsync = 1'b0; btn_left = bl; btn_right = br; widen_req = (wmode == 1);
        if (wmode != 0) m_pend = 1;
        @(negedge clk);
        widen_req = (wmode == 2);
        vsync = 1'b1;
        @(negedge clk);
        widen_req = 1'b0;
        model_tick(bl, br);
        check_outputs();
    endtask

    task automatic rand_frame(input int wmode);
        int b;
        b = $urandom_range(0, 3);
        frame(b[0], b[1], wmode);
    endtask

    initial begin
        int exp_seq[6];
        int guard;
        exp_seq = '{321, 323, 326, 330, 334, 338};
        rst = 1'b1; vsync = 1'b0; btn_left = 1'b0; btn_right = 1'b0; widen_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", int'(x), 320);
        chk("rst_radius", int'(radius), 24);
        chk("rst_wide", int'(wide), 0);
        rst = 1'b0;
        model_reset();

        repeat (3) frame(0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            frame(0, 1, 0);
            chk("right_seq", int'(x), exp_seq[i]);
        end
        frame(0, 0, 0);
        chk("release_hold", int'(x), 338);
        frame(0, 1, 0);
        chk("restart_speed", int'(x), 339);

        repeat (80) frame(1, 0, 0);
        chk("left_wall", int'(x), 184);
        frame(1, 1, 0);
        chk("both_buttons", int'(x), 184);

        frame(0, 0, 1);
        chk("grow_entry_wide", int'(wide), 1);
        chk("grow_entry_radius", int'(radius), 24);
        repeat (16) frame(1, 0, 0);
        chk("wall_grow_x", int'(x), 200);
        chk("wall_grow_radius", int'(radius), 40);

        guard = 0;
        while (m_tmr != 5 && guard < 700) begin rand_frame(0); guard++; end
        chk("reach_timer5", (m_ph == 2 && m_tmr == 5) ? 1 : 0, 1);
        rand_frame(2);
        repeat (599) rand_frame(0);
        chk("reload_still_wide", int'(radius), 40);

        guard = 0;
        while (!(m_ph == 3 && m_r == 30) && guard < 50) begin rand_frame(0); guard++; end
        chk("reach_shrink30", int'(radius), 30);
        rand_frame(1);
        chk("regrow_hold", int'(radius), 30);
        rand_frame(0);
        chk("regrow_31", int'(radius), 31);
        rand_frame(0);
        chk("regrow_32", int'(radius), 32);

        guard = 0;
        while (m_ph != 2 && guard < 50) begin rand_frame(0); guard++; end
        repeat (3) rand_frame(0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_x", int'(x), 320);
        chk("async_rst_radius", int'(radius), 24);
        chk("async_rst_wide", int'(wide), 0);
        chk("async_rst_y", int'(y), 464);
        @(negedge clk);
        vsync = 1'b0; widen_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 1500; i++) begin
            int w;
            w = ($urandom_range(0, 99) == 0) ? int'($urandom_range(1, 2)) : 0;
            if ($urandom_range(0, 7) == 0) begin
                rand_frame(w);
            end else begin
                frame(btn_left, btn_right, w);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Paddle motion and size controller. Sits directly upstream of the paddle renderer and produces its x, y and radius inputs.
Once per video frame it moves the paddle horizontally from the button inputs, with acceleration, and clamps it inside the playfield. It also runs the widen power-up: grow, hold, then shrink back to normal width.

Parameters:
LEFT, 160, playfield left edge in pixels.
MAXX, 320, playfield width; right edge = LEFT+MAXX = 480.
PD_Y, 464, fixed paddle centre row.
R_NORM, 24, normal half-width.
R_WIDE, 40, widened half-width (must be ≤ 63).
VMAX, 4, maximum speed in pixels per frame.
WIDE_FRAMES, 600, frames the paddle holds at R_WIDE.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
vsync  in  1  frame sync level from the VGA timing block; frame tick = rising edge
btn_left  in  1  move-left request, level, already debounced
btn_right  in  1  move-right request, level, already debounced
widen_req  in  1  one-cycle pulse from the brick/power-up logic
x  out  10  paddle centre column, to the renderer
y  out  10  paddle centre row, to the renderer
radius  out  6  paddle half-width, to the renderer
wide  out  1  high in every state other than NORMAL

Behaviour:
- Reset (async, rst=1) values:
  - x=320 (LEFT+MAXX/2), y=PD_Y, radius=R_NORM.
  - wide=0, speed=0, state=NORMAL, timer=0, pending=0, vsync_d=0.
- Tick and update timing:
  - vsync_d <= vsync every clock.
  - tick = vsync & ~vsync_d.
  - All state, x and radius updates happen only on the clock edge where tick=1. Outputs are registered and hold between ticks.
  - y is constant PD_Y.
- widen_req handling:
  - A widen_req pulse in any cycle sets pending.
  - pending is consumed (cleared) at the next tick.
  - widen_req coincident with a tick counts for that tick.
- Motion, evaluated each tick:
  - dir = left if only btn_left, right if only btn_right, none otherwise. Both buttons pressed counts as none.
  - Speed: if dir is none or differs from the previous tick's dir, speed = (dir is none ? 0 : 1). Otherwise speed = min(speed+1, VMAX).
  - Sequence while held: 1, 2, 3, 4, 4, ...
  - Tentative x' = x ± speed, computed in 11 bits with no wrap.
- Size FSM, evaluated each tick before the clamp:
  - NORMAL: if pending → GROW. radius stays R_NORM.
  - GROW: radius += 1 per tick. When radius reaches R_WIDE → HOLD, timer=WIDE_FRAMES.
  - HOLD: timer -= 1 per tick. pending reloads timer to WIDE_FRAMES. When timer reaches 0 → SHRINK.
  - SHRINK: radius -= 1 per tick. pending → GROW from the current radius. When radius reaches R_NORM → NORMAL.
  - In GROW, pending is consumed with no effect.
- Clamp, using the new radius r, every tick:
  - If x'-r < LEFT then x = LEFT+r.
  - Else if x'+r > LEFT+MAXX then x = LEFT+MAXX-r.
  - Else x = x'.
  - Growth against a wall therefore pushes the paddle inward.
  - Invariant after every tick: LEFT ≤ x-radius and x+radius ≤ LEFT+MAXX.
- Reset asserted mid-GROW or mid-HOLD returns immediately to the reset values listed above.
- Implementation is a 4-state encoded FSM, a timer counter wide enough for WIDE_FRAMES, a 3-bit speed counter and registered previous dir.

Test Plan:
1. Reset, then 3 ticks with no buttons → x=320, y=464, radius=24, wide=0 throughout.
2. Hold btn_right for 6 ticks → x steps 321, 323, 326, 330, 334, 338. Release for 1 tick → x holds, speed resets. Next btn_right tick → +1.
3. From x=190, hold btn_left 10 ticks → x saturates at 184 (160+24) and never drops below it. Press both buttons → x unchanged.
4. Pulse widen_req mid-frame → on the next tick state=GROW, wide=1. Radius reaches 40 after 16 ticks. Hold 600 ticks, then shrink to 24 over 16 ticks. wide=0 on return to NORMAL.
5. Paddle at x=184 (left wall) when widen begins → x tracks LEFT+radius each tick and ends at 200 when radius=40.
6. widen_req during HOLD with timer=5 → timer reloads to 600. widen_req during SHRINK at radius=30 → GROW resumes 31, 32, ... Assert rst mid-HOLD → all outputs return to reset values immediately, without waiting for a clock edge.
